// File: rtl/id_stage.sv
// id_stage: RV32I decode/operand stage feeding the ALU.
// Owns the 32-entry register file, captures operands on accept and holds
// them in a single pipeline register behind a valid/ready handshake.
// Optional feature macro: RUA_BYPASS_EN (write-through of a same-edge
// writeback into the captured operands). Default build reads the
// pre-write register value.
module id_stage #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd_addr
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    logic [XLEN-1:0] r_regs [REG_COUNT];

    logic            r_valid;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [4:0]      r_rd_addr;

    logic            w_accept;
    logic            w_wb_live;
    logic [4:0]      w_rs1_idx;
    logic [4:0]      w_rs2_idx;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_reg;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_use_imm;

    // Upstream may hand over a new instruction whenever the slot is empty
    // or is being drained this cycle; flush deliberately does not gate it.
    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_wb_live = wb_en && (wb_addr != 5'd0);

    assign w_rs1_idx = instr[19:15];
    assign w_rs2_idx = instr[24:20];
    assign w_imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign w_use_imm = (instr[6:0] == OPC_OP_IMM) || (instr[6:0] == OPC_LOAD);

    // Register file read with x0 hardwired to zero and optional write-through.
    always_comb begin
        w_rs1_val = (w_rs1_idx == 5'd0) ? '0 : r_regs[w_rs1_idx];
        w_rs2_reg = (w_rs2_idx == 5'd0) ? '0 : r_regs[w_rs2_idx];
`ifdef RUA_BYPASS_EN
        if (w_wb_live && (wb_addr == w_rs1_idx)) begin
            w_rs1_val = wb_data;
        end
        if (w_wb_live && (wb_addr == w_rs2_idx)) begin
            w_rs2_reg = wb_data;
        end
`endif
        w_rs2_val = w_use_imm ? w_imm : w_rs2_reg;
    end

    // Register file write port; writes to x0 are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_live) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Output valid: flush beats accept, accept beats drain, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Pipeline register: load decoded fields on a surviving accept, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_opcode  <= '0;
            r_funct3  <= '0;
            r_funct7  <= '0;
            r_rd_addr <= '0;
        end else if (w_accept && !flush) begin
            r_rs1     <= w_rs1_val;
            r_rs2     <= w_rs2_val;
            r_opcode  <= instr[6:0];
            r_funct3  <= instr[14:12];
            r_funct7  <= instr[31:25];
            r_rd_addr <= instr[11:7];
        end
    end

    assign out_valid = r_valid;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign opcode    = r_opcode;
    assign funct3    = r_funct3;
    assign funct7    = r_funct7;
    assign rd_addr   = r_rd_addr;

endmodule
